// File: rtl/clk_div_scheduler.sv
// Clock divider with two-requester divisor scheduling; new divisors take effect only on a half-period boundary.
// Build option: define CLK_DIV_SCHED_RR_EN for round-robin tie-breaking (default is fixed priority, requester 0 wins).
//
// state   | meaning
// S_IDLE  | stopped: counter, clk_out and k_active held at 0, waiting for a first divisor
// S_RUN   | dividing with k_active, new divisor requests accepted into the shadow
// S_PEND  | dividing, shadow divisor staged until the next counter==k_active boundary
module clk_div_scheduler #(
  parameter int W     = 26,
  parameter int K_MIN = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         req0,
  input  logic [W-1:0] k0,
  output logic         ack0,
  input  logic         req1,
  input  logic [W-1:0] k1,
  output logic         ack1,
  output logic         clk_out,
  output logic         pending,
  output logic         grant_id,
  output logic [W-1:0] k_active
);

  localparam logic [W-1:0] K_MIN_W = W'(K_MIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   r_shadow;
  logic           r_shadow_id;
  logic [W-1:0]   r_k_active;
  logic           r_clk_out;
  logic           r_pending;
  logic           r_ack0;
  logic           r_ack1;
  logic           r_grant_id;

  logic           w_open;
  logic           w_accept;
  logic           w_pick1;
  logic [W-1:0]   w_k_req;
  logic [W-1:0]   w_k_clamped;
  logic           w_wrap;

  // No acceptance at all while an ack is in flight, so a still-high req is never taken twice.
  assign w_open = en && ((r_state == S_IDLE) || (r_state == S_RUN)) && !r_ack0 && !r_ack1;
  assign w_accept = w_open && (req0 || req1);

`ifdef CLK_DIV_SCHED_RR_EN
  logic r_ptr;

  // r_ptr remembers the last winner; a tie goes to the other requester.
  assign w_pick1 = req1 && (!req0 || (r_ptr == 1'b0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 1'b1;
    end else if (w_accept) begin
      r_ptr <= w_pick1;
    end
  end
`else
  assign w_pick1 = req1 && !req0;
`endif

  assign w_k_req     = w_pick1 ? k1 : k0;
  assign w_k_clamped = (w_k_req < K_MIN_W) ? K_MIN_W : w_k_req;
  assign w_wrap      = (r_cnt == r_k_active);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_shadow_id <= 1'b0;
      r_k_active  <= '0;
      r_clk_out   <= 1'b0;
      r_pending   <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_grant_id  <= 1'b0;
    end else begin
      r_ack0 <= w_accept && !w_pick1;
      r_ack1 <= w_accept && w_pick1;
      if (!en) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_shadow    <= '0;
        r_shadow_id <= 1'b0;
        r_k_active  <= '0;
        r_clk_out   <= 1'b0;
        r_pending   <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            if (w_accept) begin
              r_k_active <= w_k_clamped;
              r_grant_id <= w_pick1;
              r_state    <= S_RUN;
            end
          end
          S_RUN: begin
            if (w_wrap) begin
              r_cnt     <= '0;
              r_clk_out <= ~r_clk_out;
            end else begin
              r_cnt <= r_cnt + W'(1);
            end
            if (w_accept) begin
              r_shadow    <= w_k_clamped;
              r_shadow_id <= w_pick1;
              r_pending   <= 1'b1;
              r_state     <= S_PEND;
            end
          end
          S_PEND: begin
            if (w_wrap) begin
              r_cnt      <= '0;
              r_clk_out  <= ~r_clk_out;
              r_k_active <= r_shadow;
              r_grant_id <= r_shadow_id;
              r_pending  <= 1'b0;
              r_state    <= S_RUN;
            end else begin
              r_cnt <= r_cnt + W'(1);
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_pending <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign clk_out  = r_clk_out;
  assign pending  = r_pending;
  assign grant_id = r_grant_id;
  assign k_active = r_k_active;

endmodule

// File: doc/clk_div_scheduler.md
CLK_DIV_SCHEDULER -- requirements
Module: clk_div_scheduler

Interface
REQ-001 SHALL have parameter W, default 26, divisor and counter width.
REQ-002 SHALL have parameter K_MIN, default 2, minimum applied divisor; smaller requests are clamped up to it.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  synchronous run enable.
REQ-006 SHALL have port req0  input  1  requester 0 (distance sensor) divisor-update request, level.
REQ-007 SHALL have port k0  input  W  requester 0 divisor.
REQ-008 SHALL have port ack0  output  1  one-cycle accept pulse to requester 0.
REQ-009 SHALL have ports req1 input 1, k1 input W, and ack1 output 1 for requester 1 (potentiometer), with the same semantics as requester 0.
REQ-010 SHALL have port clk_out  output  1  divided square wave.
REQ-011 SHALL have port pending  output  1  high while an accepted divisor awaits its boundary.
REQ-012 SHALL have port grant_id  output  1  requester whose divisor is currently active.
REQ-013 SHALL have port k_active  output  W  divisor currently in use; 0 in IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN and PENDING.
REQ-015 In RUN and PENDING, counter SHALL increment each cycle; when counter==k_active, counter SHALL go to 0 and clk_out SHALL toggle, giving F_out = F_clk / (2*(k_active+1)).
REQ-016 In IDLE, counter SHALL be 0 and clk_out 0.
REQ-017 Acceptance SHALL occur only when en=1 and state is IDLE or RUN; ackN SHALL pulse high for exactly one cycle, in the cycle after the accepting edge.
REQ-018 Requesters SHALL hold reqN and kN stable until ackN; the block SHALL sample kN at the accepting edge; reqN still high during the ack cycle SHALL NOT be re-accepted in that cycle.
REQ-019 Accepted value SHALL be max(kN, K_MIN), using an unsigned W-bit compare.
REQ-020 IDLE accept: k_active SHALL load immediately, counter SHALL be 0, clk_out SHALL be 0, and next state SHALL be RUN.
REQ-021 RUN accept: value SHALL go to a shadow register, pending SHALL be 1, and next state SHALL be PENDING; k_active SHALL be unchanged.
REQ-022 PENDING: no acceptance (acks withheld); at the next counter==k_active edge, k_active SHALL take the shadow value, clk_out SHALL toggle, counter SHALL be 0, pending SHALL be 0, and next state SHALL be RUN. No partial or glitched half-period is allowed.
REQ-023 grant_id SHALL update at the moment a value becomes active, not at acceptance.
REQ-024 Simultaneous req0 and req1 SHALL be arbitrated per REQ-030/031; the loser SHALL stay unacknowledged and retry in a later acceptance cycle.
REQ-025 When en=0, at the next edge: state SHALL go to IDLE, counter, clk_out, k_active and pending SHALL clear to 0, the shadow SHALL be discarded, and no acks SHALL be issued. An ack pulse already registered SHALL still complete.
REQ-026 The counter SHALL never exceed k_active; wrap is only via compare-equal, with no W-bit overflow path.

Reset
REQ-027 While rst=0, asynchronously: state SHALL be IDLE; counter, shadow, k_active, clk_out, pending, ack0, ack1 and grant_id SHALL be 0; and the arbitration pointer SHALL be 1, so requester 0 wins first.
REQ-028 Reset asserted mid-PENDING SHALL discard the shadow; after release the block SHALL restart from IDLE.
REQ-029 Outputs SHALL be valid on the first edge after rst deasserts.

Configuration
REQ-030 With macro CLK_DIV_SCHED_RR_EN defined, arbitration SHALL be round-robin: on a tie the requester not granted last wins, and the pointer SHALL update on every acceptance.
REQ-031 Without CLK_DIV_SCHED_RR_EN, arbitration SHALL be fixed priority with requester 0 always winning ties; the pointer register SHALL be absent.

Verification
REQ-032 Reset; en=1; req0=1 with k0=4 -> ack0 pulses one cycle later, k_active=4, and clk_out period is 10 clk cycles.
REQ-033 Running k=4; req1=1 with k1=9 mid-half-period -> ack1, pending=1; k_active switches to 9 exactly at the next toggle; next half-period is 10 cycles; grant_id=1.
REQ-034 req0 with k0=0 -> k_active=2 (K_MIN), clk_out period 6 cycles.
REQ-035 req0 and req1 high together for three acceptances: with RR_EN, grants go 0,1,0; without it, all three go to 0 while req1 waits.
REQ-036 Drop en while pending=1 -> next edge: clk_out=0, k_active=0, pending=0, and no late ack.
REQ-037 Assert rst mid-PENDING with k=9 staged -> all outputs 0 immediately; after release, req1 with k1=3 gives period 8 with grant_id=1.
